// File: rtl/mem_stage_lsu_if.sv
// Memory-side request/response bus between the MEM-stage LSU (master) and
// shared data memory (slave): req/gnt request phase, rvalid response phase.
interface mem_stage_lsu_if #(
    parameter int XLEN   = 32,
    parameter int MASK_W = XLEN / 8
);
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [MASK_W-1:0] mem_mask;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues memory requests, formats load data and
// registers a one-cycle write-back bundle. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
    parameter int XLEN   = 32,
    parameter int MASK_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_opr_res,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [XLEN-1:0]   ex_csr_rdata,
    input  logic [4:0]        ex_rd,
    input  logic [XLEN-1:0]   ex_pc4,
    input  logic              ex_rf_en,
    input  logic [1:0]        ex_wb_sel,
    input  logic [1:0]        ex_mem_op,
    input  logic [2:0]        ex_funct3,

    mem_stage_lsu_if.master   mem,

    output logic              wb_valid,
    output logic [XLEN-1:0]   wb_opr_res,
    output logic [XLEN-1:0]   wb_lsu_rdata,
    output logic [XLEN-1:0]   wb_csr_rdata,
    output logic [XLEN-1:0]   wb_pc4,
    output logic [XLEN-1:0]   wb_addr,
    output logic [XLEN-1:0]   wb_wdata,
    output logic [4:0]        wb_rd,
    output logic              wb_rf_en,
    output logic [1:0]        wb_wb_sel,
    output logic [MASK_W-1:0] wb_mask,
    output logic              lsu_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Access size from RV32I funct3; anything unrecognised behaves as a word.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: size_of = SZ_BYTE;
            3'b001, 3'b101: size_of = SZ_HALF;
            default:        size_of = SZ_WORD;
        endcase
    endfunction

    function automatic logic [1:0] lane_of(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: lane_of = a;
            SZ_HALF: lane_of = {a[1], 1'b0};
            default: lane_of = 2'b00;
        endcase
    endfunction

    function automatic logic [MASK_W-1:0] mask_of(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: mask_of = MASK_W'(1) << lane;
            SZ_HALF: mask_of = MASK_W'(3) << lane;
            default: mask_of = '1;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] wdata_of(input logic [1:0] size, input logic [XLEN-1:0] d);
        case (size)
            SZ_BYTE: wdata_of = {MASK_W{d[7:0]}};
            SZ_HALF: wdata_of = {(MASK_W / 2){d[15:0]}};
            default: wdata_of = d;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_fmt(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] sh;
        sh = rdata >> {lane, 3'b000};
        case (f3)
            3'b000:  load_fmt = {{(XLEN - 8){sh[7]}}, sh[7:0]};
            3'b001:  load_fmt = {{(XLEN - 16){sh[15]}}, sh[15:0]};
            3'b100:  load_fmt = {{(XLEN - 8){1'b0}}, sh[7:0]};
            3'b101:  load_fmt = {{(XLEN - 16){1'b0}}, sh[15:0]};
            default: load_fmt = sh;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   opr_res_q, opr_res_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [XLEN-1:0]   csr_rdata_q, csr_rdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic              rf_en_q, rf_en_d;
    logic [1:0]        wb_sel_q, wb_sel_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lane_q, lane_d;

    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   wb_opr_res_q, wb_opr_res_d;
    logic [XLEN-1:0]   wb_lsu_rdata_q, wb_lsu_rdata_d;
    logic [XLEN-1:0]   wb_csr_rdata_q, wb_csr_rdata_d;
    logic [XLEN-1:0]   wb_pc4_q, wb_pc4_d;
    logic [XLEN-1:0]   wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]   wb_wdata_q, wb_wdata_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_rf_en_q, wb_rf_en_d;
    logic [1:0]        wb_wb_sel_q, wb_wb_sel_d;
    logic [MASK_W-1:0] wb_mask_q, wb_mask_d;
    logic              misalign_q, misalign_d;

    logic              accept;
    logic              acc_is_mem;
    logic              acc_is_store;
    logic [1:0]        acc_size;
    logic [1:0]        acc_lane;
    logic              acc_trap;
    logic              mem_done;

    assign ex_ready     = (state_q == S_IDLE);
    assign accept       = ex_valid & ex_ready;
    assign acc_is_mem   = (ex_mem_op == OP_LOAD) | (ex_mem_op == OP_STORE);
    assign acc_is_store = (ex_mem_op == OP_STORE);
    assign acc_size     = size_of(ex_funct3);
    assign acc_lane     = lane_of(acc_size, ex_opr_res[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign acc_trap = acc_is_mem &
                      (((acc_size == SZ_HALF) & ex_opr_res[0]) |
                       ((acc_size == SZ_WORD) & (ex_opr_res[1:0] != 2'b00)));
`else
    assign acc_trap = 1'b0;
`endif

    // Next-state and write-back bundle; only a fire cycle updates the bundle.
    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        opr_res_d      = opr_res_q;
        wdata_d        = wdata_q;
        mask_d         = mask_q;
        csr_rdata_d    = csr_rdata_q;
        rd_d           = rd_q;
        pc4_d          = pc4_q;
        rf_en_d        = rf_en_q;
        wb_sel_d       = wb_sel_q;
        funct3_d       = funct3_q;
        lane_d         = lane_q;
        wb_valid_d     = 1'b0;
        wb_opr_res_d   = wb_opr_res_q;
        wb_lsu_rdata_d = wb_lsu_rdata_q;
        wb_csr_rdata_d = wb_csr_rdata_q;
        wb_pc4_d       = wb_pc4_q;
        wb_addr_d      = wb_addr_q;
        wb_wdata_d     = wb_wdata_q;
        wb_rd_d        = wb_rd_q;
        wb_rf_en_d     = wb_rf_en_q;
        wb_wb_sel_d    = wb_wb_sel_q;
        wb_mask_d      = wb_mask_q;
        misalign_d     = 1'b0;
        mem_done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (acc_is_mem && !acc_trap) begin
                        we_d        = acc_is_store;
                        opr_res_d   = ex_opr_res;
                        wdata_d     = acc_is_store ? wdata_of(acc_size, ex_store_data) : '0;
                        mask_d      = mask_of(acc_size, acc_lane);
                        csr_rdata_d = ex_csr_rdata;
                        rd_d        = ex_rd;
                        pc4_d       = ex_pc4;
                        rf_en_d     = ex_rf_en;
                        wb_sel_d    = ex_wb_sel;
                        funct3_d    = ex_funct3;
                        lane_d      = acc_lane;
                        state_d     = S_REQ;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_opr_res_d   = ex_opr_res;
                        wb_lsu_rdata_d = '0;
                        wb_csr_rdata_d = ex_csr_rdata;
                        wb_pc4_d       = ex_pc4;
                        wb_addr_d      = ex_opr_res;
                        wb_wdata_d     = '0;
                        wb_rd_d        = ex_rd;
                        wb_rf_en_d     = ex_rf_en & ~acc_trap;
                        wb_wb_sel_d    = ex_wb_sel;
                        wb_mask_d      = '0;
                        misalign_d     = acc_trap;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_gnt) begin
                    if (we_q) begin
                        mem_done = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    mem_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (mem_done) begin
            wb_valid_d     = 1'b1;
            wb_opr_res_d   = opr_res_q;
            wb_lsu_rdata_d = we_q ? '0 : load_fmt(funct3_q, lane_q, mem.mem_rdata);
            wb_csr_rdata_d = csr_rdata_q;
            wb_pc4_d       = pc4_q;
            wb_addr_d      = opr_res_q;
            wb_wdata_d     = wdata_q;
            wb_rd_d        = rd_q;
            wb_rf_en_d     = rf_en_q;
            wb_wb_sel_d    = wb_sel_q;
            wb_mask_d      = mask_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            we_q           <= 1'b0;
            opr_res_q      <= '0;
            wdata_q        <= '0;
            mask_q         <= '0;
            csr_rdata_q    <= '0;
            rd_q           <= '0;
            pc4_q          <= '0;
            rf_en_q        <= 1'b0;
            wb_sel_q       <= '0;
            funct3_q       <= '0;
            lane_q         <= '0;
            wb_valid_q     <= 1'b0;
            wb_opr_res_q   <= '0;
            wb_lsu_rdata_q <= '0;
            wb_csr_rdata_q <= '0;
            wb_pc4_q       <= '0;
            wb_addr_q      <= '0;
            wb_wdata_q     <= '0;
            wb_rd_q        <= '0;
            wb_rf_en_q     <= 1'b0;
            wb_wb_sel_q    <= '0;
            wb_mask_q      <= '0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            opr_res_q      <= opr_res_d;
            wdata_q        <= wdata_d;
            mask_q         <= mask_d;
            csr_rdata_q    <= csr_rdata_d;
            rd_q           <= rd_d;
            pc4_q          <= pc4_d;
            rf_en_q        <= rf_en_d;
            wb_sel_q       <= wb_sel_d;
            funct3_q       <= funct3_d;
            lane_q         <= lane_d;
            wb_valid_q     <= wb_valid_d;
            wb_opr_res_q   <= wb_opr_res_d;
            wb_lsu_rdata_q <= wb_lsu_rdata_d;
            wb_csr_rdata_q <= wb_csr_rdata_d;
            wb_pc4_q       <= wb_pc4_d;
            wb_addr_q      <= wb_addr_d;
            wb_wdata_q     <= wb_wdata_d;
            wb_rd_q        <= wb_rd_d;
            wb_rf_en_q     <= wb_rf_en_d;
            wb_wb_sel_q    <= wb_wb_sel_d;
            wb_mask_q      <= wb_mask_d;
            misalign_q     <= misalign_d;
        end
    end

    // Request fields come straight from the latch so they hold steady until gnt.
    assign mem.mem_req   = (state_q == S_REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = {opr_res_q[XLEN-1:2], 2'b00};
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_mask  = mask_q;

    assign wb_valid      = wb_valid_q;
    assign wb_opr_res    = wb_opr_res_q;
    assign wb_lsu_rdata  = wb_lsu_rdata_q;
    assign wb_csr_rdata  = wb_csr_rdata_q;
    assign wb_pc4        = wb_pc4_q;
    assign wb_addr       = wb_addr_q;
    assign wb_wdata      = wb_wdata_q;
    assign wb_rd         = wb_rd_q;
    assign wb_rf_en      = wb_rf_en_q;
    assign wb_wb_sel     = wb_wb_sel_q;
    assign wb_mask       = wb_mask_q;
    assign lsu_misalign  = misalign_q;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-access stage directly upstream of write-back. Takes one EX-stage result per accept and issues load/store requests to shared memory over a req/gnt/rvalid handshake. Aligns and sign-extends load data, generates byte masks, and emits a single-cycle registered write-back bundle (opr_res, lsu_rdata, csr_rdata, rd, pc4, rf_en, wb_sel, mask, addr, wdata).

Parameters:
XLEN, 32, datapath and address width
MASK_W, 4, byte-enable width (XLEN/8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX result valid
ex_ready  out  1  stage accepts EX result this cycle
ex_opr_res  in  XLEN  ALU result / memory address
ex_store_data  in  XLEN  rs2 value for stores
ex_csr_rdata  in  XLEN  CSR read data, passed through
ex_rd  in  5  destination register
ex_pc4  in  XLEN  PC+4
ex_rf_en  in  1  register-file write enable
ex_wb_sel  in  2  write-back mux select, passed through
ex_mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
ex_funct3  in  3  access size/sign (RV32I encoding)
mem_req  out  1  memory request
mem_we  out  1  1 store, 0 load
mem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  XLEN  lane-replicated store data
mem_mask  out  MASK_W  byte enables
mem_gnt  in  1  request accepted
mem_rvalid  in  1  load data valid
mem_rdata  in  XLEN  load data (full word)
wb_valid  out  1  write-back bundle valid (single-cycle pulse)
wb_opr_res, wb_lsu_rdata, wb_csr_rdata, wb_pc4, wb_addr, wb_wdata  out  XLEN each  registered bundle fields
wb_rd  out  5  registered rd
wb_rf_en  out  1  registered rf_en
wb_wb_sel  out  2  registered wb_sel
wb_mask  out  MASK_W  registered mask
lsu_misalign  out  1  misaligned-access pulse (see Optional Feature)

Behaviour:
- Reset: state IDLE; mem_req, mem_we, wb_valid, wb_rf_en, lsu_misalign = 0; every other registered output = 0. Reset mid-transaction abandons it; rvalid/gnt arriving afterwards are ignored in IDLE.
- ex_ready = (state == IDLE). Accept = ex_valid & ex_ready.
- FSM IDLE/REQ/WAIT:
  IDLE: accept of non-mem op -> bundle registered, wb_valid=1 next cycle, stay IDLE (1-cycle latency, back-to-back OK). Accept of load/store -> latch all inputs, go REQ.
  REQ: mem_req=1 with latched we/addr/wdata/mask held stable until gnt. On gnt: store -> wb_valid=1 next cycle, IDLE; load -> WAIT. rvalid in REQ ignored.
  WAIT: mem_req=0. On rvalid -> formatted lsu_rdata registered, wb_valid=1 next cycle, IDLE.
- Minimum latency: store 2 cycles accept->wb_valid, load 3.
- Store mask/data: SB mask 0001<<a[1:0], byte replicated x4; SH mask 0011<<{a[1],0}, half replicated x2; SW 1111. Loads: mask same rule, mem_wdata=0.
- Load format: select lane by a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word. Other funct3 treated as LW.
- Non-mem ops: wb_lsu_rdata=0, wb_mask=0. wb_addr=full byte address (ex_opr_res).
- wb_valid never asserted on two consecutive cycles for memory ops; WB has no backpressure.

Optional Feature:
MEM_MISALIGN_TRAP_EN. Defined: halfword with a[0]=1 or word with a[1:0]!=0 is not issued; stays IDLE, wb_valid=1 next cycle with wb_rf_en=0, lsu_misalign=1 for that one cycle. Undefined: misalignment ignored, offending low bits forced to 0 for mask/lane selection; lsu_misalign tied 0.

Test Plan:
- Non-mem op opr_res=0x1234, rd=5, rf_en=1 -> wb_valid next cycle, wb_opr_res=0x1234, wb_rd=5, mem_req never high.
- SB addr=0x103, data=0xAB, gnt 1 cycle after req -> mem_addr=0x100, mask=1000, wdata=0xABABABAB; wb_valid 2 cycles after accept.
- LH addr=0x102, gnt delayed 3 cycles, rdata=0x8001xxxx -> req held stable 3 cycles; wb_lsu_rdata=0xFFFF8001; LHU -> 0x00008001.
- LW with rvalid 4 cycles after gnt -> ex_ready=0 throughout; back-to-back non-mem ops then complete at 1/cycle.
- rst asserted in WAIT, then stale rvalid -> all outputs 0, no wb_valid, next accept proceeds normally.
- With MEM_MISALIGN_TRAP_EN: LW addr=0x101 -> no mem_req, lsu_misalign=1, wb_rf_en=0.
